cim_macro_req_scheduler: RTL and testbench
==========================================

// Module: cim_macro_req_scheduler
// PURPOSE
// - Shares the 9 CIM macros (8 MiB each, contiguous from 0x3000_0000) among NB_REQ requesters
//   (DMA, host port, core sequencer).
// - Decodes each request address to a macro index and arbitrates per macro (round-robin).
// - Sequences each macro through a req/gnt/rvalid transaction; routes the response to the owner.
// - Sits between the CIM core interconnect and the macro wrappers.
// PARAMETERS
// - NB_REQ  4   number of requesters (1..8)
// - DW      64  data width
// - AW      32  requester address width
// PORTS
// - clk_i         in   1              core clock
// - rst_ni        in   1              async active-low reset
// - req_valid_i   in   NB_REQ         requester request valid
// - req_ready_o   out  NB_REQ         request accepted this cycle
// - req_addr_i    in   NB_REQ*AW      byte address
// - req_we_i      in   NB_REQ         1 = write
// - req_wdata_i   in   NB_REQ*DW      write data
// - resp_valid_o  out  NB_REQ         one-cycle response pulse
// - resp_rdata_o  out  NB_REQ*DW      read data (0 for writes/errors)
// - resp_err_o    out  NB_REQ         decode error
// - mac_req_o     out  NB_MACROS      macro request
// - mac_gnt_i     in   NB_MACROS      macro grant
// - mac_addr_o    out  NB_MACROS*23   offset inside macro (addr - base)
// - mac_we_o      out  NB_MACROS      write enable
// - mac_wdata_o   out  NB_MACROS*DW   write data
// - mac_rvalid_i  in   NB_MACROS      macro response valid (reads and writes)
// - mac_rdata_i   in   NB_MACROS*DW   macro read data
// BEHAVIOUR
// - Reset: all outputs 0; every macro FSM IDLE; all RR pointers 0; no requester pending.
// - Decode: idx = (addr - 0x3000_0000) >> 23.
//   - Valid iff 0x3000_0000 <= addr < 0x3480_0000; any other addr is a decode error.
//   - Offset = addr[22:0].
// - Requester rules:
//   - One outstanding transaction per requester.
//   - req_ready_o is 0 while a transaction is pending; pending clears in the cycle resp_valid_o pulses.
//   - Payload must stay stable while valid && !ready.
// - Decode error: req_ready_o=1 in the cycle of acceptance; resp_valid_o=1, resp_err_o=1,
//   rdata=0 on the next cycle. No macro is touched.
// - Per-macro FSM:
//   - IDLE: RR arbiter picks among valid, non-pending requesters decoding to this macro.
//     Winner gets req_ready_o=1 that cycle; owner, addr, we and wdata are registered; go REQ.
//   - REQ: mac_req_o=1 with the registered payload. On mac_gnt_i, drop mac_req_o next cycle; go WAIT.
//   - WAIT: on mac_rvalid_i, capture mac_rdata_i; go RESP.
//   - RESP: resp_valid_o[owner]=1 for one cycle, rdata = captured value (0 for writes); go IDLE.
//   - Minimum latency, accept to resp_valid_o: 3 cycles, with gnt in the first REQ cycle and
//     rvalid the cycle after.
// - RR: per-macro pointer = winner+1 mod NB_REQ, updated only on acceptance.
//   Priority search starts at the pointer.
// - gnt and rvalid in the same cycle in REQ: treat as gnt, then rvalid; go directly to RESP.
// - rvalid in IDLE or REQ (protocol violation): ignored; simulation assertion fires.
// - Different macros run fully in parallel.
// - A decode-error response and a macro response can never target the same requester in the
//   same cycle, because each requester has one outstanding transaction.
// - Reset asserted mid-transaction: all state is cleared immediately and mac_req_o drops.
//   In-flight macro responses after reset release are ignored.
// STRUCTURE
// - Shared package CIM_Core_macro_addr_map gains:
//   - MacroOffsetBits=23
//   - CimRegionBase=64'h3000_0000
//   - CimRegionEnd=64'h3480_0000
//   - typedef macro_state_e {IDLE, REQ, WAIT, RESP}
// - Sub-module cim_rr_arb #(N): req vector in, one-hot gnt out, pointer update on en.
//   Instantiated NB_MACROS times.
// TESTING
// - Req0 read 0x3080_0010 -> mac_req_o[1] with mac_addr_o=0x10; gnt next cycle; rvalid with
//   rdata=0xA5 -> resp_valid_o[0]=1, rdata 0xA5, err 0.
// - Req2 addr 0x3480_0000 -> req_ready_o[2]=1 that cycle; resp_err_o[2]=1 next cycle;
//   no mac_req_o asserted.
// - Req0..3 all target macro_4 continuously -> acceptance order 0,1,2,3,0; no requester starved.
// - Req0 to macro_0, req1 to macro_8, same cycle -> both accepted that cycle;
//   responses independent and in parallel.
// - gnt and rvalid same cycle on macro_3 -> resp_valid_o pulses next cycle; FSM back to IDLE.
// - rst_ni low during WAIT -> all outputs 0 asynchronously; after release, a late rvalid
//   produces no resp_valid_o.

Source files
------------

// File: rtl/cim_macro_req_scheduler_pkg.sv
// Address map of the CIM macro region and the per-macro sequencing states.
package cim_macro_req_scheduler_pkg;

   localparam int NB_MACROS       = 9;
   localparam int MacroOffsetBits = 23;
   localparam int MacroIdxW       = 4;
   localparam logic [63:0] CimRegionBase = 64'h3000_0000;
   localparam logic [63:0] CimRegionEnd  = 64'h3480_0000;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} macro_state_e;

   function automatic logic addr_in_region(input logic [63:0] addr);
      return (addr >= CimRegionBase) && (addr < CimRegionEnd);
   endfunction

   function automatic logic [MacroIdxW-1:0] addr_to_macro(input logic [63:0] addr);
      return MacroIdxW'((addr - CimRegionBase) >> MacroOffsetBits);
   endfunction

endpackage

// File: rtl/cim_macro_req_scheduler_rr_arb.sv
// Round-robin arbiter: search starts at the pointer, pointer moves past the winner on en_i.
module cim_rr_arb #(
   parameter int N = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [N-1:0] req_i,
   input  logic         en_i,
   output logic [N-1:0] gnt_o
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_nxt;
   logic          found;

   always_comb begin
      gnt_o   = '0;
      ptr_nxt = ptr_q;
      found   = 1'b0;
      for (int i = 0; i < N; i++) begin
         int idx;
         idx = (int'(ptr_q) + i) % N;
         if (!found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            ptr_nxt    = PW'((idx + 1) % N);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= '0;
      end else if (en_i && found) begin
         ptr_q <= ptr_nxt;
      end
   end

endmodule

// File: rtl/cim_macro_req_scheduler.sv
// Decodes requester addresses onto the 9 CIM macros, arbitrates per macro and
// sequences each macro through req/gnt/rvalid, routing the response to its owner.
module cim_macro_req_scheduler
   import cim_macro_req_scheduler_pkg::*;
#(
   parameter int NB_REQ = 4,
   parameter int DW     = 64,
   parameter int AW     = 32
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic [NB_REQ-1:0]                    req_valid_i,
   output logic [NB_REQ-1:0]                    req_ready_o,
   input  logic [NB_REQ*AW-1:0]                 req_addr_i,
   input  logic [NB_REQ-1:0]                    req_we_i,
   input  logic [NB_REQ*DW-1:0]                 req_wdata_i,
   output logic [NB_REQ-1:0]                    resp_valid_o,
   output logic [NB_REQ*DW-1:0]                 resp_rdata_o,
   output logic [NB_REQ-1:0]                    resp_err_o,
   output logic [NB_MACROS-1:0]                 mac_req_o,
   input  logic [NB_MACROS-1:0]                 mac_gnt_i,
   output logic [NB_MACROS*MacroOffsetBits-1:0] mac_addr_o,
   output logic [NB_MACROS-1:0]                 mac_we_o,
   output logic [NB_MACROS*DW-1:0]              mac_wdata_o,
   input  logic [NB_MACROS-1:0]                 mac_rvalid_i,
   input  logic [NB_MACROS*DW-1:0]              mac_rdata_i
);

   localparam int RW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

   macro_state_e               state_q [NB_MACROS];
   logic [RW-1:0]              owner_q [NB_MACROS];
   logic [MacroOffsetBits-1:0] addr_q  [NB_MACROS];
   logic [DW-1:0]              wdata_q [NB_MACROS];
   logic [DW-1:0]              rdata_q [NB_MACROS];
   logic [NB_MACROS-1:0]       we_q;
   logic [NB_MACROS-1:0]       armed_q;
   logic [NB_REQ-1:0]          pending_q, err_q;

   logic [NB_REQ-1:0]          dec_ok, err_acc, accept;
   logic [MacroIdxW-1:0]       dec_idx [NB_REQ];
   logic [NB_REQ-1:0]          arb_req [NB_MACROS];
   logic [NB_REQ-1:0]          arb_gnt [NB_MACROS];
   logic [RW-1:0]              win_idx [NB_MACROS];
   logic [NB_REQ-1:0]          resp_valid;

   always_comb begin
      for (int r = 0; r < NB_REQ; r++) begin
         dec_ok[r]  = addr_in_region(64'(req_addr_i[r*AW +: AW]));
         dec_idx[r] = addr_to_macro(64'(req_addr_i[r*AW +: AW]));
         err_acc[r] = req_valid_i[r] && !pending_q[r] && !dec_ok[r];
      end
      for (int m = 0; m < NB_MACROS; m++) begin
         for (int r = 0; r < NB_REQ; r++) begin
            arb_req[m][r] = req_valid_i[r] && !pending_q[r] && dec_ok[r] &&
                            (dec_idx[r] == MacroIdxW'(m)) && (state_q[m] == IDLE);
         end
      end
   end

   for (genvar m = 0; m < NB_MACROS; m++) begin : g_arb
      cim_rr_arb #(.N(NB_REQ)) u_arb (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .req_i  (arb_req[m]),
         .en_i   (state_q[m] == IDLE),
         .gnt_o  (arb_gnt[m])
      );

      // Stale rvalids from before a reset are legitimately ignored, hence the armed gate.
      a_rvalid_protocol : assert property (@(posedge clk_i) disable iff (!rst_ni)
         !(armed_q[m] && mac_rvalid_i[m] &&
           ((state_q[m] == IDLE) || ((state_q[m] == REQ) && !mac_gnt_i[m]))));
   end

   always_comb begin
      accept       = err_acc;
      resp_valid   = err_q;
      resp_rdata_o = '0;
      mac_req_o    = '0;
      mac_addr_o   = '0;
      mac_we_o     = '0;
      mac_wdata_o  = '0;
      for (int m = 0; m < NB_MACROS; m++) begin
         win_idx[m] = '0;
         for (int r = 0; r < NB_REQ; r++) begin
            if (arb_gnt[m][r]) win_idx[m] = RW'(r);
         end
         accept = accept | arb_gnt[m];
         if (state_q[m] == REQ) begin
            mac_req_o[m]                                    = 1'b1;
            mac_addr_o[m*MacroOffsetBits +: MacroOffsetBits] = addr_q[m];
            mac_we_o[m]                                     = we_q[m];
            mac_wdata_o[m*DW +: DW]                         = wdata_q[m];
         end
         if (state_q[m] == RESP) begin
            resp_valid[owner_q[m]]                    = 1'b1;
            resp_rdata_o[int'(owner_q[m])*DW +: DW]  |= rdata_q[m];
         end
      end
   end

   assign req_ready_o  = rst_ni ? accept : '0;
   assign resp_valid_o = resp_valid;
   assign resp_err_o   = err_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pending_q <= '0;
         err_q     <= '0;
         armed_q   <= '0;
         for (int m = 0; m < NB_MACROS; m++) begin
            state_q[m] <= IDLE;
            owner_q[m] <= '0;
         end
      end else begin
         err_q     <= err_acc;
         pending_q <= (pending_q & ~resp_valid) | accept;
         for (int m = 0; m < NB_MACROS; m++) begin
            case (state_q[m])
               IDLE: if (|arb_gnt[m]) begin
                  owner_q[m] <= win_idx[m];
                  armed_q[m] <= 1'b1;
                  state_q[m] <= REQ;
               end
               REQ:  if (mac_gnt_i[m]) state_q[m] <= mac_rvalid_i[m] ? RESP : WAIT;
               WAIT: if (mac_rvalid_i[m]) state_q[m] <= RESP;
               RESP: state_q[m] <= IDLE;
               default: state_q[m] <= IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i) begin
      for (int m = 0; m < NB_MACROS; m++) begin
         if ((state_q[m] == IDLE) && (|arb_gnt[m])) begin
            addr_q[m]  <= req_addr_i[int'(win_idx[m])*AW +: MacroOffsetBits];
            we_q[m]    <= req_we_i[win_idx[m]];
            wdata_q[m] <= req_wdata_i[int'(win_idx[m])*DW +: DW];
         end
         if (((state_q[m] == REQ) && mac_gnt_i[m] && mac_rvalid_i[m]) ||
             ((state_q[m] == WAIT) && mac_rvalid_i[m])) begin
            rdata_q[m] <= we_q[m] ? '0 : mac_rdata_i[m*DW +: DW];
         end
      end
   end

endmodule

// File: tb/tb_cim_macro_req_scheduler.sv
// Directed bench for cim_macro_req_scheduler with hand-computed expectations.
module tb_cim_macro_req_scheduler;

   localparam int NB_REQ = 4;
   localparam int DW     = 64;
   localparam int AW     = 32;
   localparam int NM     = 9;
   localparam int OB     = 23;

   logic                clk_i = 1'b0;
   logic                rst_ni;
   logic [NB_REQ-1:0]   req_valid_i;
   logic [NB_REQ-1:0]   req_ready_o;
   logic [NB_REQ*AW-1:0] req_addr_i;
   logic [NB_REQ-1:0]   req_we_i;
   logic [NB_REQ*DW-1:0] req_wdata_i;
   logic [NB_REQ-1:0]   resp_valid_o;
   logic [NB_REQ*DW-1:0] resp_rdata_o;
   logic [NB_REQ-1:0]   resp_err_o;
   logic [NM-1:0]       mac_req_o;
   logic [NM-1:0]       mac_gnt_i;
   logic [NM*OB-1:0]    mac_addr_o;
   logic [NM-1:0]       mac_we_o;
   logic [NM*DW-1:0]    mac_wdata_o;
   logic [NM-1:0]       mac_rvalid_i;
   logic [NM*DW-1:0]    mac_rdata_i;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk_i = ~clk_i;

   cim_macro_req_scheduler #(.NB_REQ(NB_REQ), .DW(DW), .AW(AW)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_addr_i   (req_addr_i),
      .req_we_i     (req_we_i),
      .req_wdata_i  (req_wdata_i),
      .resp_valid_o (resp_valid_o),
      .resp_rdata_o (resp_rdata_o),
      .resp_err_o   (resp_err_o),
      .mac_req_o    (mac_req_o),
      .mac_gnt_i    (mac_gnt_i),
      .mac_addr_o   (mac_addr_o),
      .mac_we_o     (mac_we_o),
      .mac_wdata_o  (mac_wdata_o),
      .mac_rvalid_i (mac_rvalid_i),
      .mac_rdata_i  (mac_rdata_i)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_req(input int r, input logic v, input logic [31:0] addr,
                          input logic we, input logic [63:0] wdata);
      req_valid_i[r]          = v;
      req_addr_i[r*AW +: AW]  = addr;
      req_we_i[r]             = we;
      req_wdata_i[r*DW +: DW] = wdata;
   endtask

   task automatic set_mac(input int m, input logic gnt, input logic rv, input logic [63:0] rdata);
      mac_gnt_i[m]            = gnt;
      mac_rvalid_i[m]         = rv;
      mac_rdata_i[m*DW +: DW] = rdata;
   endtask

   initial begin
      rst_ni       = 1'b0;
      req_valid_i  = '0;
      req_addr_i   = '0;
      req_we_i     = '0;
      req_wdata_i  = '0;
      mac_gnt_i    = '0;
      mac_rvalid_i = '0;
      mac_rdata_i  = '0;

      // reset: valid request must not be accepted, all outputs quiet
      set_req(0, 1'b1, 32'h3080_0010, 1'b0, 64'h0);
      #12;
      check("rst_ready", 64'(req_ready_o), 64'h0);
      check("rst_resp_valid", 64'(resp_valid_o), 64'h0);
      check("rst_mac_req", 64'(mac_req_o), 64'h0);
      req_valid_i = '0;
      #3 rst_ni = 1'b1;
      tick();

      // single read to macro 1
      set_req(0, 1'b1, 32'h3080_0010, 1'b0, 64'h0);
      #1 check("rd_ready", 64'(req_ready_o), 64'h1);
      tick();
      req_valid_i = '0;
      #1 check("rd_mac_req", 64'(mac_req_o), 64'h002);
      check("rd_mac_addr", 64'(mac_addr_o[1*OB +: OB]), 64'h10);
      check("rd_mac_we", 64'(mac_we_o), 64'h0);
      set_mac(1, 1'b1, 1'b0, 64'h0);
      tick();
      set_mac(1, 1'b0, 1'b1, 64'hA5);
      #1 check("rd_wait_mac_req", 64'(mac_req_o), 64'h0);
      tick();
      set_mac(1, 1'b0, 1'b0, 64'h0);
      #1 check("rd_resp_valid", 64'(resp_valid_o), 64'h1);
      check("rd_resp_rdata", resp_rdata_o[0 +: DW], 64'hA5);
      check("rd_resp_err", 64'(resp_err_o), 64'h0);
      tick();
      check("rd_resp_done", 64'(resp_valid_o), 64'h0);

      // decode error at region end
      set_req(2, 1'b1, 32'h3480_0000, 1'b0, 64'h0);
      #1 check("err_ready", 64'(req_ready_o), 64'h4);
      tick();
      req_valid_i = '0;
      #1 check("err_resp_valid", 64'(resp_valid_o), 64'h4);
      check("err_resp_err", 64'(resp_err_o), 64'h4);
      check("err_resp_rdata", resp_rdata_o[2*DW +: DW], 64'h0);
      check("err_no_mac_req", 64'(mac_req_o), 64'h0);
      tick();
      check("err_done", 64'(resp_valid_o), 64'h0);

      // all requesters hammer macro 4: order 0,1,2,3,0
      for (int r = 0; r < NB_REQ; r++) set_req(r, 1'b1, 32'h3200_0000 + 32'(r*8), 1'b0, 64'h0);
      for (int k = 0; k < 5; k++) begin
         int e;
         e = k % 4;
         #1 check($sformatf("rr_ready_%0d", k), 64'(req_ready_o), 64'(1 << e));
         tick();
         if (k == 4) req_valid_i = '0;
         set_mac(4, 1'b1, 1'b0, 64'h0);
         tick();
         set_mac(4, 1'b0, 1'b1, 64'h100 + 64'(k));
         tick();
         set_mac(4, 1'b0, 1'b0, 64'h0);
         #1 check($sformatf("rr_resp_%0d", k), 64'(resp_valid_o), 64'(1 << e));
         check($sformatf("rr_rdata_%0d", k), resp_rdata_o[e*DW +: DW], 64'h100 + 64'(k));
         tick();
      end

      // macro 0 read and macro 8 write in parallel
      set_req(0, 1'b1, 32'h3000_0100, 1'b0, 64'h0);
      set_req(1, 1'b1, 32'h3400_0008, 1'b1, 64'h1234);
      #1 check("par_ready", 64'(req_ready_o), 64'h3);
      tick();
      req_valid_i = '0;
      #1 check("par_mac_req", 64'(mac_req_o), 64'h101);
      check("par_addr0", 64'(mac_addr_o[0 +: OB]), 64'h100);
      check("par_addr8", 64'(mac_addr_o[8*OB +: OB]), 64'h8);
      check("par_we", 64'(mac_we_o), 64'h100);
      check("par_wdata8", mac_wdata_o[8*DW +: DW], 64'h1234);
      set_mac(0, 1'b1, 1'b0, 64'h0);
      tick();
      set_mac(0, 1'b0, 1'b1, 64'h77);
      set_mac(8, 1'b1, 1'b0, 64'h0);
      #1 check("par_mac_req_8only", 64'(mac_req_o), 64'h100);
      tick();
      set_mac(0, 1'b0, 1'b0, 64'h0);
      set_mac(8, 1'b0, 1'b1, 64'hFFFF);
      #1 check("par_resp0", 64'(resp_valid_o), 64'h1);
      check("par_rdata0", resp_rdata_o[0 +: DW], 64'h77);
      tick();
      set_mac(8, 1'b0, 1'b0, 64'h0);
      #1 check("par_resp1", 64'(resp_valid_o), 64'h2);
      check("par_rdata1_write", resp_rdata_o[1*DW +: DW], 64'h0);
      tick();

      // gnt and rvalid together on macro 3
      set_req(3, 1'b1, 32'h3180_0040, 1'b0, 64'h0);
      #1 check("gr_ready", 64'(req_ready_o), 64'h8);
      tick();
      req_valid_i = '0;
      set_mac(3, 1'b1, 1'b1, 64'hDEAD);
      tick();
      set_mac(3, 1'b0, 1'b0, 64'h0);
      #1 check("gr_resp", 64'(resp_valid_o), 64'h8);
      check("gr_rdata", resp_rdata_o[3*DW +: DW], 64'hDEAD);
      tick();
      check("gr_resp_done", 64'(resp_valid_o), 64'h0);

      // macro 3 back in IDLE; start macro 3 and macro 5, reset during macro 3 WAIT
      set_req(3, 1'b1, 32'h3180_0080, 1'b0, 64'h0);
      set_req(1, 1'b1, 32'h3280_0000, 1'b0, 64'h0);
      #1 check("rst_pre_ready", 64'(req_ready_o), 64'hA);
      tick();
      req_valid_i = '0;
      #1 check("rst_pre_mac_req", 64'(mac_req_o), 64'h028);
      set_mac(3, 1'b1, 1'b0, 64'h0);
      tick();
      set_mac(3, 1'b0, 1'b0, 64'h0);
      #1 check("rst_wait_mac_req", 64'(mac_req_o), 64'h020);
      #1 rst_ni = 1'b0;
      #1 check("rst_async_mac_req", 64'(mac_req_o), 64'h0);
      check("rst_async_resp", 64'(resp_valid_o), 64'h0);
      check("rst_async_ready", 64'(req_ready_o), 64'h0);
      #2 rst_ni = 1'b1;
      tick();
      set_mac(3, 1'b0, 1'b1, 64'hBEEF);
      tick();
      set_mac(3, 1'b0, 1'b0, 64'h0);
      #1 check("late_rvalid_resp", 64'(resp_valid_o), 64'h0);
      check("late_mac_req", 64'(mac_req_o), 64'h0);
      tick();
      check("late_rvalid_resp2", 64'(resp_valid_o), 64'h0);

      // fresh transaction after reset
      set_req(0, 1'b1, 32'h3080_0020, 1'b0, 64'h0);
      #1 check("post_ready", 64'(req_ready_o), 64'h1);
      tick();
      req_valid_i = '0;
      #1 check("post_mac_req", 64'(mac_req_o), 64'h002);
      set_mac(1, 1'b1, 1'b1, 64'h42);
      tick();
      set_mac(1, 1'b0, 1'b0, 64'h0);
      #1 check("post_resp", 64'(resp_valid_o), 64'h1);
      check("post_rdata", resp_rdata_o[0 +: DW], 64'h42);
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
